mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multicycle MIPS main controller: sequences the shared ALU/memory datapath by driving the
//  select lines of the 2/3/4-input datapath muxes (iord, alusrca, alusrcb, pcsrc, memtoreg,
//  regdst) and the register/memory write enables. It also handles the memory ready handshake,
//  runs a memory-wait watchdog and halts on a timeout.
// PARAMETERS
//  WAIT_MAX  15  max wait cycles per memory access before halting (0 = watchdog disabled)
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous reset, active-high
//  op         in   6  instr[31:26] from instruction register
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory access completes in this cycle
//  mem_req    out  1  memory access request (FETCH/MEMRD/MEMWR)
//  memwrite   out  1  memory write strobe
//  irwrite    out  1  instruction register load
//  regwrite   out  1  register file write
//  pcen       out  1  PC load = pcwrite | (branch & zero)
//  iord       out  1  address mux select: 0 = PC, 1 = ALUOut
//  alusrca    out  1  ALU A select: 0 = PC, 1 = A
//  alusrcb    out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//  aluop      out  2  00 = add, 01 = sub, 10 = funct
//  pcsrc      out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
//  memtoreg   out  1  write-data select: 0 = ALUOut, 1 = Data
//  regdst     out  1  dest select: 0 = rt, 1 = rd
//  illegal_op out  1  one-cycle pulse in DECODE for an unsupported opcode
//  mem_err    out  1  sticky watchdog error
//  state      out  4  current state encoding, for debug
// BEHAVIOUR
//  - State encoding: IDLE=0 FETCH=1 DECODE=2 MEMADR=3 MEMRD=4 MEMWB=5 MEMWR=6 RTYPEEX=7
//    RTYPEWB=8 BEQEX=9 ADDIEX=10 ADDIWB=11 JEX=12 HALT=13. Codes 14/15 go to IDLE.
//  - Reset: state = IDLE, wait counter = 0, mem_err = 0. In IDLE every output is 0.
//    IDLE -> FETCH after one cycle. Reset mid-instruction drops the access immediately.
//  - Outputs are Moore, decoded from state. Any output not listed for a state is 0.
//    Exceptions: irwrite/pcwrite in FETCH are gated by mem_ready, and pcen includes zero.
//  - FETCH: mem_req, iord=0, alusrca=0, alusrcb=01, pcsrc=00.
//    In the mem_ready cycle: irwrite=1, pcwrite=1, next = DECODE. Otherwise stay in FETCH.
//  - DECODE: alusrca=0, alusrcb=11. Next state by op:
//    100011 (LW) or 101011 (SW) -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX;
//    001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH with illegal_op=1.
//  - MEMADR: alusrca=1, alusrcb=10. Next MEMRD if op=LW, else MEMWR.
//  - MEMRD: mem_req, iord=1. Go to MEMWB on mem_ready.
//  - MEMWB: memtoreg=1, regdst=0, regwrite. Next FETCH.
//  - MEMWR: mem_req, iord=1, memwrite held for the whole state. Go to FETCH on mem_ready.
//  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next RTYPEWB.
//  - RTYPEWB: regdst=1, regwrite. Next FETCH.
//  - BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch -> pcen=zero. Next FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10. Next ADDIWB.
//  - ADDIWB: regdst=0, memtoreg=0, regwrite. Next FETCH.
//  - JEX: pcsrc=10, pcwrite. Next FETCH.
//  - Watchdog (memory states FETCH/MEMRD/MEMWR only):
//    counter increments each cycle the state waits with mem_ready=0, and clears on state exit.
//    If WAIT_MAX>0 and the counter reaches WAIT_MAX-1 while mem_ready=0, next state = HALT and
//    mem_err sets. A mem_ready arriving in that same cycle wins: no error.
//  - HALT: all outputs 0 except mem_err=1. Leaves HALT only on reset.
//  - Instruction latency with zero wait states: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3 cycles.
// TESTING
//  1. reset high, then released, mem_ready=1, op=000000 -> IDLE, FETCH, DECODE, RTYPEEX,
//     RTYPEWB, FETCH; regwrite=1 with regdst=1 in RTYPEWB only.
//  2. op=100011, mem_ready held low 3 cycles in MEMRD -> state stays 4 for 3 cycles, then MEMWB
//     with memtoreg=1; mem_err=0.
//  3. op=000100: zero=1 -> pcen=1 in BEQEX; zero=0 -> pcen=0. Both runs return to FETCH.
//  4. WAIT_MAX=15, mem_ready=0 in FETCH -> HALT after 15 cycles, mem_err=1 sticky;
//     a later reset clears it and returns to IDLE.
//  5. op=111111 -> illegal_op pulses for 1 cycle in DECODE, next state FETCH, no write strobe.
//  6. reset asserted mid-MEMWR -> all outputs 0 immediately, state=0; mem_err unaffected (0).

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: Moore FSM that steers the shared ALU/memory datapath,
// handshakes with memory via mem_ready and halts if a memory access stalls too long.
module mc_ctrl_fsm #(
   parameter int WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       memtoreg,
   output logic       regdst,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      FETCH   = 4'd1,
      DECODE  = 4'd2,
      MEMADR  = 4'd3,
      MEMRD   = 4'd4,
      MEMWB   = 4'd5,
      MEMWR   = 4'd6,
      RTYPEEX = 4'd7,
      RTYPEWB = 4'd8,
      BEQEX   = 4'd9,
      ADDIEX  = 4'd10,
      ADDIWB  = 4'd11,
      JEX     = 4'd12,
      HALT    = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CW-1:0] WAIT_LIM = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
   localparam bit WDOG_ON = (WAIT_MAX > 0);

   state_t          cur_state;
   state_t          nxt_state;
   logic [CW-1:0]   wait_cnt;
   logic            mem_err_q;
   logic            pcwrite;
   logic            branch;
   logic            is_mem_state;
   logic            timeout;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // The wait counter only ever advances while a memory state is stalled; any exit clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         if (is_mem_state && (nxt_state == cur_state)) begin
            wait_cnt <= wait_cnt + CW'(1);
         end else begin
            wait_cnt <= '0;
         end
         if ((cur_state != HALT) && (nxt_state == HALT)) begin
            mem_err_q <= 1'b1;
         end
      end
   end

   assign is_mem_state = (cur_state == FETCH) || (cur_state == MEMRD) || (cur_state == MEMWR);
   assign timeout      = WDOG_ON && (wait_cnt == WAIT_LIM) && !mem_ready;

   always_comb begin
      nxt_state  = cur_state;
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      illegal_op = 1'b0;
      case (cur_state)
         IDLE: nxt_state = FETCH;
         FETCH: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            if (mem_ready) begin
               irwrite   = 1'b1;
               pcwrite   = 1'b1;
               nxt_state = DECODE;
            end else if (timeout) begin
               nxt_state = HALT;
            end
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: nxt_state = MEMADR;
               OP_RTYPE:     nxt_state = RTYPEEX;
               OP_BEQ:       nxt_state = BEQEX;
               OP_ADDI:      nxt_state = ADDIEX;
               OP_J:         nxt_state = JEX;
               default: begin
                  illegal_op = 1'b1;
                  nxt_state  = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            nxt_state = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               nxt_state = MEMWB;
            end else if (timeout) begin
               nxt_state = HALT;
            end
         end
         MEMWB: begin
            memtoreg  = 1'b1;
            regwrite  = 1'b1;
            nxt_state = FETCH;
         end
         MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) begin
               nxt_state = FETCH;
            end else if (timeout) begin
               nxt_state = HALT;
            end
         end
         RTYPEEX: begin
            alusrca   = 1'b1;
            aluop     = 2'b10;
            nxt_state = RTYPEWB;
         end
         RTYPEWB: begin
            regdst    = 1'b1;
            regwrite  = 1'b1;
            nxt_state = FETCH;
         end
         BEQEX: begin
            alusrca   = 1'b1;
            aluop     = 2'b01;
            pcsrc     = 2'b01;
            branch    = 1'b1;
            nxt_state = FETCH;
         end
         ADDIEX: begin
            alusrca   = 1'b1;
            alusrcb   = 2'b10;
            nxt_state = ADDIWB;
         end
         ADDIWB: begin
            regwrite  = 1'b1;
            nxt_state = FETCH;
         end
         JEX: begin
            pcsrc     = 2'b10;
            pcwrite   = 1'b1;
            nxt_state = FETCH;
         end
         HALT: nxt_state = HALT;
         default: nxt_state = IDLE;
      endcase
   end

   assign pcen    = pcwrite | (branch & zero);
   assign mem_err = mem_err_q;
   assign state   = cur_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized scoreboard bench for mc_ctrl_fsm: an instruction-level model expands each
// instruction into per-cycle expected control words that a monitor compares every cycle.
module tb_mc_ctrl_fsm;

   localparam int WAIT_MAX = 15;

   localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3;
   localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR = 4'd6,   S_RTYPEEX = 4'd7;
   localparam logic [3:0] S_RTYPEWB = 4'd8, S_BEQEX = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11;
   localparam logic [3:0] S_JEX = 4'd12, S_HALT = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, memwrite, irwrite, regwrite, pcen, iord, alusrca;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic       memtoreg, regdst, illegal_op, mem_err;
   logic [3:0] state;

   mc_ctrl_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .pcen(pcen), .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
      .pcsrc(pcsrc), .memtoreg(memtoreg), .regdst(regdst), .illegal_op(illegal_op),
      .mem_err(mem_err), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] state;
      logic       mem_req, memwrite, irwrite, regwrite, pcen, iord, alusrca;
      logic [1:0] alusrcb, aluop, pcsrc;
      logic       memtoreg, regdst, illegal_op, mem_err;
   } obs_t;

   typedef struct {
      logic       rst;
      logic       ready;
      logic       z;
      logic [5:0] op;
      obs_t       exp;
   } rec_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         fetch_wait;
      int         data_wait;
      bit         rst_mid;
   } instr_t;

   rec_t stim_q[$];
   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   logic [5:0] legal_ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(logic [5:0] o);
      foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
      return 1'b0;
   endfunction

   function automatic obs_t blank(logic [3:0] s);
      obs_t o;
      o = '0;
      o.state = s;
      return o;
   endfunction

   function automatic obs_t mem_obs(logic [3:0] s, logic ready);
      obs_t o;
      o = blank(s);
      o.mem_req = 1'b1;
      if (s == S_FETCH) begin
         o.alusrcb = 2'b01;
         o.irwrite = ready;
         o.pcen    = ready;
      end else begin
         o.iord     = 1'b1;
         o.memwrite = (s == S_MEMWR);
      end
      return o;
   endfunction

   function automatic instr_t mk(logic [5:0] o, logic z, int fw, int dw, bit rm);
      instr_t t;
      t.op = o; t.z = z; t.fetch_wait = fw; t.data_wait = dw; t.rst_mid = rm;
      return t;
   endfunction

   task automatic push(logic rst, logic ready, logic z, logic [5:0] o, obs_t e);
      rec_t r;
      r.rst = rst; r.ready = ready; r.z = z; r.op = o; r.exp = e;
      stim_q.push_back(r);
   endtask

   task automatic reset_seq();
      push(1'b1, rbit(), rbit(), 6'($urandom_range(0, 63)), blank(S_IDLE));
      push(1'b0, rbit(), rbit(), 6'($urandom_range(0, 63)), blank(S_IDLE));
   endtask

   // A memory access of w wait cycles: completes, is cut short by reset, or trips the watchdog.
   task automatic mem_phase(logic [3:0] s, int w, logic [5:0] o, bit abort_mid, output bit broke);
      int n;
      broke = 1'b0;
      if (abort_mid) begin
         push(1'b0, 1'b0, rbit(), o, mem_obs(s, 1'b0));
         reset_seq();
         broke = 1'b1;
         return;
      end
      n = (w < WAIT_MAX) ? w : WAIT_MAX;
      for (int i = 0; i < n; i++) push(1'b0, 1'b0, rbit(), o, mem_obs(s, 1'b0));
      if (w >= WAIT_MAX) begin
         obs_t h;
         h = blank(S_HALT);
         h.mem_err = 1'b1;
         for (int k = 0; k < 3 + int'($urandom_range(0, 3)); k++) push(1'b0, rbit(), rbit(), o, h);
         reset_seq();
         broke = 1'b1;
      end else begin
         push(1'b0, 1'b1, rbit(), o, mem_obs(s, 1'b1));
      end
   endtask

   task automatic run_instr(instr_t t);
      bit   broke;
      obs_t o;
      mem_phase(S_FETCH, t.fetch_wait, t.op, 1'b0, broke);
      if (broke) return;
      o = blank(S_DECODE);
      o.alusrcb = 2'b11;
      o.illegal_op = !is_legal(t.op);
      push(1'b0, rbit(), rbit(), t.op, o);
      if (!is_legal(t.op)) return;
      case (t.op)
         OP_LW, OP_SW: begin
            o = blank(S_MEMADR); o.alusrca = 1'b1; o.alusrcb = 2'b10;
            push(1'b0, rbit(), rbit(), t.op, o);
            if (t.op == OP_LW) begin
               mem_phase(S_MEMRD, t.data_wait, t.op, 1'b0, broke);
               if (!broke) begin
                  o = blank(S_MEMWB); o.memtoreg = 1'b1; o.regwrite = 1'b1;
                  push(1'b0, rbit(), rbit(), t.op, o);
               end
            end else begin
               mem_phase(S_MEMWR, t.data_wait, t.op, t.rst_mid, broke);
            end
         end
         OP_RTYPE: begin
            o = blank(S_RTYPEEX); o.alusrca = 1'b1; o.aluop = 2'b10;
            push(1'b0, rbit(), rbit(), t.op, o);
            o = blank(S_RTYPEWB); o.regdst = 1'b1; o.regwrite = 1'b1;
            push(1'b0, rbit(), rbit(), t.op, o);
         end
         OP_BEQ: begin
            o = blank(S_BEQEX); o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = t.z;
            push(1'b0, rbit(), t.z, t.op, o);
         end
         OP_ADDI: begin
            o = blank(S_ADDIEX); o.alusrca = 1'b1; o.alusrcb = 2'b10;
            push(1'b0, rbit(), rbit(), t.op, o);
            o = blank(S_ADDIWB); o.regwrite = 1'b1;
            push(1'b0, rbit(), rbit(), t.op, o);
         end
         default: begin
            o = blank(S_JEX); o.pcsrc = 2'b10; o.pcen = 1'b1;
            push(1'b0, rbit(), rbit(), t.op, o);
         end
      endcase
   endtask

   task automatic applyStimulus(rec_t r);
      reset     = r.rst;
      mem_ready = r.ready;
      zero      = r.z;
      op        = r.op;
   endtask

   task automatic checkOutput(obs_t e);
      obs_t got;
      got.state = state;     got.mem_req = mem_req;   got.memwrite = memwrite;
      got.irwrite = irwrite; got.regwrite = regwrite; got.pcen = pcen;
      got.iord = iord;       got.alusrca = alusrca;   got.alusrcb = alusrcb;
      got.aluop = aluop;     got.pcsrc = pcsrc;       got.memtoreg = memtoreg;
      got.regdst = regdst;   got.illegal_op = illegal_op; got.mem_err = mem_err;
      checks++;
      if (got !== e) begin
         errors++;
         $display("[TB] FAIL ctrl_word cycle %0d: got state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                  cycle, got.state, got, e.state, e);
      end
   endtask

   always @(negedge clk) begin
      cycle++;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
   end

   initial begin
      rec_t r;
      int   sel, rw;
      instr_t t;
      reset_seq();
      run_instr(mk(OP_RTYPE, 1'b0, 0, 0, 1'b0));
      run_instr(mk(OP_LW, 1'b0, 0, 3, 1'b0));
      run_instr(mk(OP_BEQ, 1'b1, 0, 0, 1'b0));
      run_instr(mk(OP_BEQ, 1'b0, 0, 0, 1'b0));
      run_instr(mk(6'b111111, 1'b0, 0, 0, 1'b0));
      run_instr(mk(OP_SW, 1'b0, 0, 2, 1'b1));
      run_instr(mk(OP_ADDI, 1'b0, 1, 0, 1'b0));
      run_instr(mk(OP_J, 1'b0, 0, 0, 1'b0));
      run_instr(mk(OP_SW, 1'b0, 0, 2, 1'b0));
      run_instr(mk(OP_RTYPE, 1'b0, 15, 0, 1'b0));
      run_instr(mk(OP_LW, 1'b0, 14, 14, 1'b0));
      run_instr(mk(OP_LW, 1'b0, 0, 15, 1'b0));
      for (int n = 0; n < 120; n++) begin
         sel = int'($urandom_range(0, 7));
         t.op = (sel < 6) ? legal_ops[sel] : 6'($urandom_range(0, 63));
         t.z = rbit();
         rw = int'($urandom_range(0, 39));
         t.fetch_wait = (rw < 36) ? rw % 4 : ((rw < 38) ? 14 : 15);
         rw = int'($urandom_range(0, 39));
         t.data_wait = (rw < 35) ? rw % 4 : ((rw < 37) ? 14 : 15 + rw % 3);
         t.rst_mid = ($urandom_range(0, 19) == 0);
         run_instr(t);
      end
      while (stim_q.size() > 0) begin
         @(posedge clk);
         #1;
         r = stim_q.pop_front();
         applyStimulus(r);
         exp_q.push_back(r.exp);
      end
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: got no end of run, expected completion within 50000 cycles");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
